// File: rtl/bc_tx.sv
// bc_tx: barcode station-ID transmitter.
// Sends START, 8 data bits MSB first, then a high GAP, as pulse-width-coded
// symbols on BC. One pending ID can be queued while a frame is in flight.
// Optional build macro BC_PARITY_EN adds an odd-parity symbol after bit 0.
module bc_tx #(
    parameter int BIT_T = 1024,  // clocks per symbol, multiple of 4, >= 8
    parameter int GAP_T = 4096   // clocks of idle-high gap after a frame, >= 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       send,
    input  logic [7:0] id,
    output logic       BC,
    output logic       busy,
    output logic       done,
    output logic       pend_full,
    output logic       ovr
);

    localparam int CW = $clog2(BIT_T);
    localparam int GW = (GAP_T > 1) ? $clog2(GAP_T) : 1;

    localparam logic [CW-1:0] SYM_LAST = CW'(BIT_T - 1);
    localparam logic [CW-1:0] L_START  = CW'(BIT_T / 2);
    localparam logic [CW-1:0] L_ZERO   = CW'(BIT_T / 4);
    localparam logic [CW-1:0] L_ONE    = CW'(3 * BIT_T / 4);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_T - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_GAP
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_bit;
    logic [GW-1:0] r_gap;
    logic [7:0]    r_shift;
    logic [7:0]    r_pend_id;
    logic          r_pend_full;
    logic          r_bc;
    logic          r_busy;
    logic          r_done;
    logic          r_ovr;
`ifdef BC_PARITY_EN
    logic          r_par;
    logic          w_par_n;
`endif

    state_t        w_state_n;
    logic [CW-1:0] w_cnt_n;
    logic [2:0]    w_bit_n;
    logic [GW-1:0] w_gap_n;
    logic [7:0]    w_shift_n;
    logic [7:0]    w_pend_id_n;
    logic          w_pend_full_n;
    logic          w_bc_n;
    logic          w_busy_n;
    logic          w_done_n;
    logic          w_ovr_n;

    logic          w_sym_end;
    logic          w_gap_last;
    logic          w_consume;
    logic          w_direct;
    logic          w_launch;
    logic [7:0]    w_launch_id;

    // A new frame starts either from the pending slot at the end of GAP, or
    // directly from send when nothing is queued and the line is (about to be) free.
    assign w_sym_end   = (r_cnt == SYM_LAST);
    assign w_gap_last  = (r_state == S_GAP) && (r_gap == GAP_LAST);
    assign w_consume   = w_gap_last && r_pend_full;
    assign w_direct    = send && ((r_state == S_IDLE) || (w_gap_last && !r_pend_full));
    assign w_launch    = w_consume || w_direct;
    assign w_launch_id = w_consume ? r_pend_id : id;

    // State register: FSM, counters, pending slot and registered outputs.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_bit       <= '0;
            r_gap       <= '0;
            r_shift     <= '0;
            r_pend_id   <= '0;
            r_pend_full <= 1'b0;
            r_bc        <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_ovr       <= 1'b0;
`ifdef BC_PARITY_EN
            r_par       <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_n;
            r_cnt       <= w_cnt_n;
            r_bit       <= w_bit_n;
            r_gap       <= w_gap_n;
            r_shift     <= w_shift_n;
            r_pend_id   <= w_pend_id_n;
            r_pend_full <= w_pend_full_n;
            r_bc        <= w_bc_n;
            r_busy      <= w_busy_n;
            r_done      <= w_done_n;
            r_ovr       <= w_ovr_n;
`ifdef BC_PARITY_EN
            r_par       <= w_par_n;
`endif
        end
    end

    // Next-state logic: symbol sequencing, frame launch and pending-slot update.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        w_state_n     = r_state;
        w_cnt_n       = r_cnt;
        w_bit_n       = r_bit;
        w_gap_n       = r_gap;
        w_shift_n     = r_shift;
        w_pend_id_n   = r_pend_id;
        w_pend_full_n = r_pend_full;
`ifdef BC_PARITY_EN
        w_par_n       = r_par;
`endif

        case (r_state)
            S_IDLE: begin
                w_cnt_n = '0;
            end
            S_START: begin
                if (w_sym_end) begin
                    w_state_n = S_DATA;
                    w_cnt_n   = '0;
                    w_bit_n   = '0;
                end else begin
                    w_cnt_n = r_cnt + 1'b1;
                end
            end
            S_DATA: begin
                if (w_sym_end) begin
                    w_cnt_n = '0;
                    if (r_bit == 3'd7) begin
`ifdef BC_PARITY_EN
                        w_state_n = S_PARITY;
`else
                        w_state_n = S_GAP;
                        w_gap_n   = '0;
`endif
                    end else begin
                        w_bit_n   = r_bit + 1'b1;
                        w_shift_n = {r_shift[6:0], 1'b0};
                    end
                end else begin
                    w_cnt_n = r_cnt + 1'b1;
                end
            end
`ifdef BC_PARITY_EN
            S_PARITY: begin
                if (w_sym_end) begin
                    w_state_n = S_GAP;
                    w_cnt_n   = '0;
                    w_gap_n   = '0;
                end else begin
                    w_cnt_n = r_cnt + 1'b1;
                end
            end
`endif
            S_GAP: begin
                w_gap_n = r_gap + 1'b1;
            end
            default: begin
                w_state_n = S_IDLE;
            end
        endcase

        // Frame launch overrides GAP/IDLE handling; otherwise GAP ends in IDLE.
        if (w_launch) begin
            w_state_n = S_START;
            w_cnt_n   = '0;
            w_bit_n   = '0;
            w_gap_n   = '0;
            w_shift_n = w_launch_id;
`ifdef BC_PARITY_EN
            w_par_n   = ~^w_launch_id;
`endif
        end else if (w_gap_last) begin
            w_state_n = S_IDLE;
            w_gap_n   = '0;
        end

        // Pending slot: refilled in the same cycle it is drained, otherwise
        // a send while a frame is in flight lands here if the slot is free.
        if (w_consume) begin
            w_pend_full_n = send;
            if (send) begin
                w_pend_id_n = id;
            end
        end else if (send && !w_direct && !r_pend_full) begin
            w_pend_full_n = 1'b1;
            w_pend_id_n   = id;
        end
    end

    // Output decode from the next state so BC and flags come straight from flops.
    always_comb begin
        w_busy_n = (w_state_n != S_IDLE);
        w_done_n = (w_state_n == S_GAP) && (r_state != S_GAP);
        w_ovr_n  = send && r_pend_full && !w_gap_last;
        case (w_state_n)
            S_START: w_bc_n = (w_cnt_n >= L_START);
            S_DATA:  w_bc_n = (w_cnt_n >= (w_shift_n[7] ? L_ONE : L_ZERO));
`ifdef BC_PARITY_EN
            S_PARITY: w_bc_n = (w_cnt_n >= (w_par_n ? L_ONE : L_ZERO));
`endif
            default: w_bc_n = 1'b1;
        endcase
    end

    assign BC        = r_bc;
    assign busy      = r_busy;
    assign done      = r_done;
    assign pend_full = r_pend_full;
    assign ovr       = r_ovr;

endmodule

// File: tb/tb_bc_tx.sv
// tb_bc_tx: self-checking bench for bc_tx (BIT_T=16, GAP_T=20).
// A frame-level reference model expands each accepted ID into its expected
// per-cycle waveform; every cycle all five outputs are compared against it.
// Build with BC_PARITY_EN defined to exercise the parity variant.
module tb_bc_tx;

    localparam int B = 16;
    localparam int G = 20;
`ifdef BC_PARITY_EN
    localparam int NS = 10;
`else
    localparam int NS = 9;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       send;
    logic [7:0] id;
    logic       BC;
    logic       busy;
    logic       done;
    logic       pend_full;
    logic       ovr;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    bc_tx #(.BIT_T(B), .GAP_T(G)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .send      (send),
        .id        (id),
        .BC        (BC),
        .busy      (busy),
        .done      (done),
        .pend_full (pend_full),
        .ovr       (ovr)
    );

    // Reference model: queue of expected outputs, front = current cycle.
    typedef struct packed {
        logic bc;
        logic dn;
    } slot_t;

    slot_t      q[$];
    logic       m_pend    = 1'b0;
    logic [7:0] m_pend_id = 8'h00;
    logic       m_ovr     = 1'b0;

    // Expand one frame into per-cycle BC values: low count per symbol, then GAP.
    function automatic void push_frame(input logic [7:0] d);
        slot_t s;
        int    lo;
        for (int k = 0; k < NS; k++) begin
            if (k == 0)
                lo = B / 2;
            else if (k <= 8)
                lo = d[8-k] ? (3 * B / 4) : (B / 4);
            else
                lo = ($countones(d) % 2 == 0) ? (3 * B / 4) : (B / 4);
            for (int c = 0; c < B; c++) begin
                s.bc = (c >= lo);
                s.dn = 1'b0;
                q.push_back(s);
            end
        end
        for (int g = 0; g < G; g++) begin
            s.bc = 1'b1;
            s.dn = (g == 0);
            q.push_back(s);
        end
    endfunction

    // Advance the model by one clock edge with the inputs seen at that edge.
    function automatic void model_edge(input logic s, input logic [7:0] d, input logic r);
        logic       idle;
        logic       last_gap;
        logic       launch;
        logic [7:0] lid;
        m_ovr  = 1'b0;
        launch = 1'b0;
        lid    = 8'h00;
        if (!r) begin
            q.delete();
            m_pend = 1'b0;
            return;
        end
        idle     = (q.size() == 0);
        last_gap = (q.size() == 1);
        if (last_gap && m_pend) begin
            launch = 1'b1;
            lid    = m_pend_id;
            m_pend = s;
            if (s) m_pend_id = d;
        end else if (s && (idle || last_gap)) begin
            launch = 1'b1;
            lid    = d;
        end else if (s) begin
            if (m_pend) m_ovr = 1'b1;
            else begin
                m_pend    = 1'b1;
                m_pend_id = d;
            end
        end
        if (!idle) void'(q.pop_front());
        if (launch) push_frame(lid);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    // One clock: drive inputs, take the edge, update model, compare on negedge.
    task automatic step(input logic s, input logic [7:0] d, input logic r);
        slot_t f;
        send  = s;
        id    = d;
        rst_n = r;
        @(posedge clk);
        model_edge(s, d, r);
        cyc++;
        @(negedge clk);
        f = (q.size() > 0) ? q[0] : slot_t'(2'b10);
        check("bc",        32'(BC),        32'(f.bc));
        check("busy",      32'(busy),      32'(q.size() > 0));
        check("done",      32'(done),      32'(f.dn));
        check("pend_full", 32'(pend_full), 32'(m_pend));
        check("ovr",       32'(ovr),       32'(m_ovr));
    endtask

    // Idle cycles with a scrambled id to show id is ignored unless accepted.
    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'($urandom), 1'b1);
    endtask

    initial begin
        int n;
        send  = 1'b0;
        id    = 8'h00;
        rst_n = 1'b0;
        @(negedge clk);

        // Reset state
        step(1'b0, 8'h00, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        run(3);

        // Single A5 frame: done and busy timing relative to acceptance
        step(1'b1, 8'hA5, 1'b1);
        n = 1;
        while (!done && n < 400) begin
            run(1);
            n++;
        end
        check("t1_done_cycle", 32'(n), 32'(NS * B + 1));
        while (busy && n < 400) begin
            run(1);
            n++;
        end
        check("t1_busy_fall_cycle", 32'(n), 32'(NS * B + G + 1));
        run(5);

        // All-zero and all-one frames, id scrambled during flight
        step(1'b1, 8'h00, 1'b1);
        run(NS * B + G + 5);
        step(1'b1, 8'hFF, 1'b1);
        run(NS * B + G + 5);

        // Pending ID sent back-to-back
        step(1'b1, 8'h3C, 1'b1);
        run(49);
        step(1'b1, 8'h81, 1'b1);
        check("t3_pend_full", 32'(pend_full), 32'd1);
        run(2 * (NS * B + G) + 5);

        // Overflow drop, then send during the last GAP clock with pending
        step(1'b1, 8'h11, 1'b1);
        run(10);
        step(1'b1, 8'h22, 1'b1);
        run(5);
        step(1'b1, 8'h77, 1'b1);
        check("t4_ovr_pulse", 32'(ovr), 32'd1);
        run(1);
        check("t4_ovr_clear", 32'(ovr), 32'd0);
        n = 0;
        while (q.size() != 1 && n < 400) begin
            run(1);
            n++;
        end
        check("t4_reach_last_gap", 32'(q.size()), 32'd1);
        step(1'b1, 8'h99, 1'b1);
        check("t4_lastgap_no_ovr", 32'(ovr), 32'd0);
        check("t4_lastgap_pend", 32'(pend_full), 32'd1);
        run(2 * (NS * B + G) + 5);

        // Reset in the middle of a data bit with a pending ID
        step(1'b1, 8'hC3, 1'b1);
        run(20);
        step(1'b1, 8'h5A, 1'b1);
        run(B * 3 + 4);
        step(1'b0, 8'h00, 1'b0);
        check("t5_rst_bc", 32'(BC), 32'd1);
        check("t5_rst_busy", 32'(busy), 32'd0);
        check("t5_rst_pend", 32'(pend_full), 32'd0);
        step(1'b1, 8'h6E, 1'b1);
        run(NS * B + G + 5);

        // Parity-sensitive ids
        step(1'b1, 8'h01, 1'b1);
        run(NS * B + G + 2);
        step(1'b1, 8'h00, 1'b1);
        run(NS * B + G + 2);

        // send held high: one frame, one pending, ovr pulses
        for (int i = 0; i < 60; i++) step(1'b1, 8'($urandom), 1'b1);
        run(2 * (NS * B + G) + 5);

        // Random traffic with occasional resets
        for (int i = 0; i < 4000; i++)
            step(($urandom_range(0, 39) == 0), 8'($urandom), ($urandom_range(0, 1499) != 0));
        run(2 * (NS * B + G) + 5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bc_tx.md
Name: bc_tx

Overview:
- Barcode station-ID transmitter: the sending end of the serial link whose receiver produces ID and ID_vld for the command controller.
- Serializes an 8-bit station ID onto a single pulse-width-coded line, BC.
- Used in station beacons and as the stimulus source in the follower-level bench.
- Holds one pending ID so back-to-back stations are sent with a guaranteed inter-frame gap.

Parameters:
- BIT_T, 1024: clocks per symbol period; must be a multiple of 4 and at least 8.
- GAP_T, 4096: clocks BC is held high between frames; at least 1.

Ports:
- clk  input  1  system clock (50MHz)
- rst_n  input  1  synchronous active-low reset
- send  input  1  request to transmit id; sampled every clk
- id  input  8  station ID, captured in the cycle send is accepted
- BC  output  1  serial barcode line, idles high
- busy  output  1  high from frame start through end of GAP
- done  output  1  one-clk pulse when the last symbol of a frame completes
- pend_full  output  1  pending slot occupied
- ovr  output  1  one-clk pulse when send is dropped

Behaviour:
- Reset: rst_n low at a clk edge clears everything, mid-frame or not.
  - Outputs: BC=1, busy=0, done=0, pend_full=0, ovr=0.
  - State: IDLE; counters 0; pending slot emptied.
- Symbol coding, each symbol BIT_T clocks: BC low for the first L clocks, then high for the rest.
  - START: L=BIT_T/2.
  - Data bit '0': L=BIT_T/4.
  - Data bit '1': L=3*BIT_T/4.
- Frame: START, then 8 data bits MSB first (id[7] first), then GAP of GAP_T clocks with BC high.
- FSM states: IDLE -> START -> DATA (8 symbols, 3-bit bit counter) -> [PARITY] -> GAP -> IDLE or START.
  - Symbol counter runs 0..BIT_T-1 and wraps at each symbol boundary.
- BC is registered and glitch-free.
- Latency: send accepted in IDLE at edge k gives BC=0 and busy=1 from edge k+1.
- done pulses in the first GAP cycle.
- busy drops at the edge after the last GAP clock unless a pending ID exists.
- Pending rules:
  - send while busy and pend_full=0: id stored, pend_full=1.
  - send while pend_full=1: request dropped, ovr=1 for one clk, stored ID unchanged.
  - Last GAP clock with pend_full=1: pending ID loaded, next edge enters START (busy stays 1, no idle cycle), pend_full clears.
    - A send in that same cycle is stored into the slot being freed: pend_full stays 1, no ovr.
  - Last GAP clock with pend_full=0 and send=1: ID goes directly to START, as if idle.
- id is sampled only on acceptance; later changes to id do not affect the frame in flight.
- send held high is a new request every cycle. Holding send continuously therefore yields one frame + one pending + ovr pulses.

Optional Feature:
- Macro BC_PARITY_EN.
- Defined:
  - A PARITY symbol follows bit 0, coded like a data bit, carrying odd parity (XOR of id, inverted).
  - Frame length becomes 10 symbols + GAP.
  - done pulses after PARITY.
- Undefined: no parity symbol, frame is 9 symbols, no parity logic synthesized.

Test Plan (BIT_T=16, GAP_T=20):
1. Reset, then send=1 with id=8'hA5 for one clk -> from the next edge BC low 8 clks / high 8. Then bits 1,0,1,0,0,1,0,1 as low 12/4/12/4/4/12/4/12 clks. done pulses at clk 145, busy falls after clk 164.
2. id=8'h00 then id=8'hFF frames -> every data symbol low exactly 4 (resp. 12) clks. Change id mid-frame -> waveform unchanged.
3. send 8'h3C, then send 8'h81 at clk 50 -> pend_full=1. Second frame's START begins the clk after GAP ends, busy never drops between frames, pend_full clears then.
4. With pend_full=1, pulse send with 8'h77 -> ovr one clk, 8'h77 never transmitted. Send during last GAP clock with pending -> accepted, no ovr.
5. Assert rst_n=0 for one clk in the middle of bit 3 -> next cycle BC=1, busy=0, pend_full=0. A fresh send then transmits a complete correct frame.
6. BC_PARITY_EN defined, id=8'h01 -> 10th symbol is '0' (low 4 clks). id=8'h00 -> parity '1' (low 12 clks). done is delayed by 16 clks versus the undefined build.
